rom_fetch_ctrl: RTL and testbench

ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

---
 rtl/rom_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_ctrl.sv
`default_nettype none
// rom_fetch_ctrl: burst ROM fetch controller with a credit-limited output FIFO.
// Build option: define ROM_FETCH_DESC_EN to step addresses downward (-1 per issue).
module rom_fetch_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [LEN_W-1:0]      remain_q, remain_d;
  logic                  tag1_q, tag2_q;
  logic                  zero_done_q, zero_done_d;
  logic                  issue, drain_done;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            in_flight;
  logic [CNT_W:0]        occupancy;
  logic                  has_room, wr_en, rd_en;

  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef ROM_FETCH_DESC_EN
    return a - ADDR_WIDTH'(1);
`else
    return a + ADDR_WIDTH'(1);
`endif
  endfunction

  // Words already issued reserve a FIFO slot, so the FIFO can never overflow.
  assign in_flight = {1'b0, tag1_q} + {1'b0, tag2_q};
  assign occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(in_flight);
  assign has_room  = (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  assign wr_en     = tag2_q;
  assign out_valid = (count_q != '0);
  assign rd_en     = out_valid & out_ready;
  assign count_d   = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  assign out_data  = mem_q[rd_ptr_q];

  assign rom_addr  = rom_addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (drain_done | zero_done_q) & ~rst;

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    issue_addr  = addr_q;
    remain_d    = remain_q;
    zero_done_d = 1'b0;
    drain_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // A start coinciding with the zero-length done pulse is dropped.
        if (start && !zero_done_q) begin
          if (len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            issue      = 1'b1;
            issue_addr = base_addr;
            remain_d   = len - LEN_W'(1);
            state_d    = (len == LEN_W'(1)) ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (has_room) begin
          issue    = 1'b1;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (in_flight == 2'd0 && count_q == '0) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rom_addr_d = issue ? issue_addr : rom_addr_q;
    addr_d     = issue ? step_addr(issue_addr) : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rom_addr_q  <= '0;
      remain_q    <= '0;
      tag1_q      <= 1'b0;
      tag2_q      <= 1'b0;
      zero_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rom_addr_q  <= rom_addr_d;
      remain_q    <= remain_d;
      tag1_q      <= issue;
      tag2_q      <= tag1_q;
      zero_done_q <= zero_done_d;
      count_q     <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= rom_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_ctrl.sv
`default_nettype none
// tb_rom_fetch_ctrl: directed self-checking bench; ROM model returns addr + 0x100.
module tb_rom_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  base_addr;
  logic [7:0]  len;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  rom_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= 12'h100 + {5'b0, rom_addr};

  function automatic logic [6:0] nxt(input logic [6:0] a);
`ifdef ROM_FETCH_DESC_EN
    return a - 7'd1;
`else
    return a + 7'd1;
`endif
  endfunction

  function automatic logic [11:0] word(input logic [6:0] a);
    return 12'h100 + {5'b0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collects words until done, checking order, word count and a single done pulse.
  task automatic drain(input logic [6:0] base, input int n, input bit rnd,
                       input int budget, input string tag);
    logic [6:0] a;
    int got;
    int dones;
    int cyc;
    a = base;
    got = 0;
    dones = 0;
    cyc = 0;
    while (dones == 0 && cyc < budget) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) dones++;
      if (out_valid && out_ready) begin
        check({tag, "_data"}, 32'(out_data), 32'(word(a)));
        a = nxt(a);
        got++;
      end
      tick();
      cyc++;
    end
    check({tag, "_count"}, 32'(got), 32'(n));
    check({tag, "_done_seen"}, 32'(dones), 32'd1);
    check({tag, "_done_low_after"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    logic [6:0] a;
    bit         seen;

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Latency: base=1 len=4, words in cycles 3..6, done in cycle 7.
    base_addr = 7'd1; len = 8'd4; start = 1'b1;
    tick(); start = 1'b0;
    a = 7'd1;
    check("lat_c1_rom_addr", 32'(rom_addr), 32'(a));
    check("lat_c1_busy", 32'(busy), 32'd1);
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_c2_rom_addr", 32'(rom_addr), 32'(nxt(a)));
    check("lat_c2_valid", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_data", 32'(out_data), 32'(word(a)));
      a = nxt(a);
      tick();
    end
    check("lat_c7_done", 32'(done), 32'd1);
    check("lat_c7_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_c8_done", 32'(done), 32'd0);
    check("lat_c8_busy", 32'(busy), 32'd0);

    // Address wrap at both ends of the ROM.
    base_addr = 7'd126; len = 8'd4; start = 1'b1;
    tick(); start = 1'b0;
    drain(7'd126, 4, 1'b0, 50, "wrap_hi");
    base_addr = 7'd1; len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    drain(7'd1, 3, 1'b0, 50, "wrap_lo");

    // Zero length, plus a start during the done pulse that must be dropped.
    base_addr = 7'd9; len = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_valid", 32'(out_valid), 32'd0);
    len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    check("len0_done_once", 32'(done), 32'd0);
    check("start_at_done_ignored", 32'(busy), 32'd0);
    check("len0_valid_later", 32'(out_valid), 32'd0);
    tick();
    check("start_at_done_still_idle", 32'(busy), 32'd0);

    // Start while busy is ignored.
    base_addr = 7'd20; len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    base_addr = 7'd50; len = 8'd5; start = 1'b1;
    tick(); start = 1'b0;
    a = 7'd20;
    for (int i = 0; i < 3; i++) begin
      check("midstart_data", 32'(out_data), 32'(word(a)));
      a = nxt(a);
      tick();
    end
    check("midstart_done", 32'(done), 32'd1);
    tick();
    check("midstart_busy_after", 32'(busy), 32'd0);
    check("midstart_valid_after", 32'(out_valid), 32'd0);

    // Backpressure: FIFO fills, issue stalls, then everything drains in order.
    out_ready = 1'b0;
    base_addr = 7'd10; len = 8'd8; start = 1'b1;
    tick(); start = 1'b0;
    a = nxt(nxt(nxt(7'd10)));
    repeat (4) tick();
    check("stall_c5_rom_addr", 32'(rom_addr), 32'(a));
    repeat (5) tick();
    check("stall_c10_rom_addr", 32'(rom_addr), 32'(a));
    check("stall_c10_valid", 32'(out_valid), 32'd1);
    check("stall_c10_head", 32'(out_data), 32'(word(7'd10)));
    check("stall_c10_done", 32'(done), 32'd0);
    drain(7'd10, 8, 1'b0, 60, "stall");

    // Reset after two words aborts silently.
    base_addr = 7'd40; len = 8'd8; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("abort_w0", 32'(out_data), 32'(word(7'd40)));
    tick();
    check("abort_w1", 32'(out_data), 32'(word(nxt(7'd40))));
    tick();
    rst = 1'b1;
    check("abort_done_in_rst", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rom_addr", 32'(rom_addr), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done || out_valid) seen = 1'b1;
      tick();
    end
    check("abort_quiet", 32'(seen), 32'd0);

    // Full-length burst with random backpressure.
    base_addr = 7'd5; len = 8'd128; start = 1'b1;
    tick(); start = 1'b0;
    drain(7'd5, 128, 1'b1, 3000, "rand128");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
